mem_bus_if: RTL
===============

MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets the block.
REQ-003 stall  in  6  pipeline stall vector; bit i set = stage i held.
REQ-004 flush  in  1  pipeline flush (exception).
REQ-005 cpu_ce_i  in  1  MEM-stage access request.
REQ-006 cpu_we_i  in  1  1 = store, 0 = load.
REQ-007 cpu_addr_i  in  32  byte address.
REQ-008 cpu_sel_i  in  4  byte lane enables.
REQ-009 cpu_data_i  in  32  store data.
REQ-010 cpu_data_o  out  32  load data to MEM stage.
REQ-011 stallreq  out  1  pipeline stall request.
REQ-012 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  bus cycle, strobe, write.
REQ-013 wb_adr_o  out  32; wb_sel_o  out  4; wb_dat_o  out  32  registered bus request fields.
REQ-014 wb_dat_i  in  32; wb_ack_i  in  1  bus read data, acknowledge.
REQ-015 bus_err_o  out  1  one-cycle timeout pulse (present only with MEM_BUS_TIMEOUT_EN).

Function
REQ-016 FSM states: IDLE, BUSY, WAIT_STALL.
REQ-017 IDLE: cpu_ce_i=1 and flush=0 -> register cyc=stb=1, we/adr/sel/dat from cpu inputs, go BUSY; otherwise stay IDLE.
REQ-018 BUSY, wb_ack_i=1: clear cyc/stb/we/adr/sel/dat to 0, capture wb_dat_i into rd_buf, go WAIT_STALL if stall!=0, else IDLE.
REQ-019 BUSY, flush=1: flush has priority over ack; clear all bus outputs, leave rd_buf unchanged, go IDLE.
REQ-020 BUSY, no ack, no flush: hold all bus outputs unchanged.
REQ-021 WAIT_STALL: go IDLE when stall==6'b0; remain otherwise; flush=1 forces IDLE.
REQ-022 stallreq (combinational): 1 in IDLE when cpu_ce_i=1 and flush=0; 1 in BUSY when wb_ack_i=0; 0 in all other cases.
REQ-023 cpu_data_o (combinational): wb_dat_i in BUSY with wb_ack_i=1; rd_buf in WAIT_STALL; 0 otherwise.
REQ-024 Store acks behave as load acks; captured data is ignored by MEM.
REQ-025 Exactly one bus transaction per accepted request; IDLE does not re-issue while the pipeline holds the same instruction in WAIT_STALL.
REQ-026 wb_ack_i outside BUSY is ignored.

Reset
REQ-027 rst==0: state=IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_sel_o=wb_dat_o=0, rd_buf=0, timeout count=0, bus_err_o=0.
REQ-028 Reset during BUSY abandons the transaction; stallreq=0 in the first cycle after reset unless cpu_ce_i=1.

Configuration
REQ-029 MEM_BUS_TIMEOUT_EN defined: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
REQ-030 When count reaches 255 with no ack: clear bus outputs, rd_buf=0, bus_err_o=1 for one cycle, go IDLE.
REQ-031 MEM_BUS_TIMEOUT_EN undefined: no counter; bus_err_o tied 0; BUSY waits indefinitely.

Structure
REQ-032 State encodings (2-bit), the timeout limit 8'd255, and the bus width constants live in the shared defines file.
REQ-033 The timeout counter is a sub-module, mem_bus_timeout, instantiated only under MEM_BUS_TIMEOUT_EN.

Verification
REQ-034 Load, ack after 3 cycles, stall=0: stallreq high for 4 cycles; cpu_data_o=32'hDEADBEEF in the ack cycle; back to IDLE.
REQ-035 Store addr 32'h100, sel 4'b0011, data 32'h1234: wb_adr_o/wb_sel_o/wb_dat_o match while BUSY; all 0 after ack.
REQ-036 Ack while stall=6'b001111: WAIT_STALL holds cpu_data_o=rd_buf until stall=0; exactly one cyc assertion.
REQ-037 flush together with ack in BUSY: IDLE next cycle; rd_buf unchanged; stallreq=0.
REQ-038 rst=0 mid-BUSY: all outputs 0 next cycle.
REQ-039 With MEM_BUS_TIMEOUT_EN and no ack: bus_err_o pulses after 255 BUSY cycles; cyc=0; state IDLE.

Source files
------------

// File: rtl/mem_bus_if_pkg.sv
// Shared constants, state encoding and bus request record for the MEM-stage bus interface.
package mem_bus_if_pkg;

    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned SelWidth     = 4;
    localparam int unsigned StallWidth   = 6;
    localparam int unsigned TimeoutWidth = 8;

    localparam logic [TimeoutWidth-1:0] TimeoutLimit = 8'd255;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StBusy      = 2'b01,
        StWaitStall = 2'b10
    } state_e;

    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [AddrWidth-1:0] adr;
        logic [SelWidth-1:0]  sel;
        logic [DataWidth-1:0] dat;
    } wb_req_t;

    localparam wb_req_t WbReqIdle = '0;

endpackage

// File: rtl/mem_bus_timeout.sv
// Bus timeout counter: cleared when a request is issued, counts BUSY cycles without ack.
module mem_bus_timeout
    import mem_bus_if_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic count_en_i,
    output logic expired_o
);

    logic [TimeoutWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose un-acked increment brings the count to the limit.
    assign expired_o = count_en_i && (cnt_q == TimeoutLimit - 8'd1);

endmodule

// File: rtl/mem_bus_if.sv
// MEM-stage to Wishbone bridge: one registered bus transaction per accepted request.
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_if
    import mem_bus_if_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [StallWidth-1:0] stall,
    input  logic                  flush,
    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [AddrWidth-1:0]  cpu_addr_i,
    input  logic [SelWidth-1:0]   cpu_sel_i,
    input  logic [DataWidth-1:0]  cpu_data_i,
    output logic [DataWidth-1:0]  cpu_data_o,
    output logic                  stallreq,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [AddrWidth-1:0]  wb_adr_o,
    output logic [SelWidth-1:0]   wb_sel_o,
    output logic [DataWidth-1:0]  wb_dat_o,
    input  logic [DataWidth-1:0]  wb_dat_i,
    input  logic                  wb_ack_i,
    output logic                  bus_err_o
);

    state_e               state_q, state_d;
    wb_req_t              req_q, req_d;
    logic [DataWidth-1:0] rd_buf_q, rd_buf_d;
    logic                 issue;
    logic                 timeout;
    logic                 timeout_hit;

    assign issue = (state_q == StIdle) && cpu_ce_i && !flush;

`ifdef MEM_BUS_TIMEOUT_EN
    logic bus_err_q;

    mem_bus_timeout u_timeout (
        .clk       (clk),
        .rst       (rst),
        .start_i   (issue),
        .count_en_i((state_q == StBusy) && !wb_ack_i),
        .expired_o (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // Flush outranks ack, which outranks timeout.
    assign timeout_hit = (state_q == StBusy) && !flush && !wb_ack_i && timeout;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rd_buf_d = rd_buf_q;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    req_d.cyc = 1'b1;
                    req_d.stb = 1'b1;
                    req_d.we  = cpu_we_i;
                    req_d.adr = cpu_addr_i;
                    req_d.sel = cpu_sel_i;
                    req_d.dat = cpu_data_i;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (flush) begin
                    req_d   = WbReqIdle;
                    state_d = StIdle;
                end else if (wb_ack_i) begin
                    req_d    = WbReqIdle;
                    rd_buf_d = wb_dat_i;
                    state_d  = (stall != '0) ? StWaitStall : StIdle;
                end else if (timeout_hit) begin
                    req_d    = WbReqIdle;
                    rd_buf_d = '0;
                    state_d  = StIdle;
                end
            end
            StWaitStall: begin
                // Pipeline still holds the same instruction; do not re-issue it.
                if (flush || (stall == '0)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = WbReqIdle;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            req_q    <= WbReqIdle;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = '0;
        unique case (state_q)
            StIdle: begin
                stallreq = cpu_ce_i && !flush;
            end
            StBusy: begin
                stallreq = !wb_ack_i;
                if (wb_ack_i) begin
                    cpu_data_o = wb_dat_i;
                end
            end
            StWaitStall: begin
                cpu_data_o = rd_buf_q;
            end
            default: begin
                stallreq   = 1'b0;
                cpu_data_o = '0;
            end
        endcase
    end

    assign wb_cyc_o = req_q.cyc;
    assign wb_stb_o = req_q.stb;
    assign wb_we_o  = req_q.we;
    assign wb_adr_o = req_q.adr;
    assign wb_sel_o = req_q.sel;
    assign wb_dat_o = req_q.dat;

endmodule
